// File: rtl/trigger_capture.sv
// trigger_capture: level/edge trigger with hysteresis, decimated circular capture buffer,
// pre-trigger depth, auto/normal/single modes and an addressed registered read port.
module trigger_capture #(
  parameter int DATA_W  = 12,
  parameter int DEPTH   = 512,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int DECIM_W = 16,
  parameter int TMO_W   = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [DATA_W-1:0]  level,
  input  logic [DATA_W-1:0]  hyst,
  input  logic               edge_fall,
  input  logic [1:0]         mode,
  input  logic [DECIM_W-1:0] decim,
  input  logic [ADDR_W-1:0]  pretrig,
  input  logic [TMO_W-1:0]   auto_tmo,
  input  logic               arm,
  input  logic               abort,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0]  rd_data,
  output logic               busy,
  output logic               armed,
  output logic               done,
  output logic               forced
);
  typedef enum logic [2:0] {IDLE, FILL_PRE, ARMED, POST, DONE} state_t;
  localparam logic [ADDR_W-1:0]  A_ONE = 1;
  localparam logic [ADDR_W:0]    P_ONE = 1;
  localparam logic [ADDR_W:0]    P_DEPTH = DEPTH;
  localparam logic [TMO_W-1:0]   T_ONE = 1;
  localparam logic [DECIM_W-1:0] D_ONE = 1;
  localparam logic [DATA_W:0]    D_MAX = {1'b0, {DATA_W{1'b1}}};
  state_t state, state_n;
  logic [DATA_W-1:0]  level_l, hyst_l;
  logic               edge_l, arm_e;
  logic [1:0]         mode_l;
  logic [DECIM_W-1:0] decim_l, div_cnt;
  logic [ADDR_W-1:0]  pretrig_l, pre_cnt, wr_ptr, start_ptr;
  logic [ADDR_W:0]    post_cnt, post_len;
  logic [TMO_W-1:0]   tmo_l, tmo_cnt;
  logic [DATA_W:0]    d_x, lvl_x, diff, sum, lo, hi;
  logic               tick, acc_arm, wr_en, set_e, fire_c, fire, force_t, trig;
  logic [DATA_W-1:0]  mem [DEPTH];
  // Thresholds are formed one bit wider so the saturation of level-hyst and level+hyst is exact.
  always_comb begin
    d_x      = {1'b0, data_in};
    lvl_x    = {1'b0, level_l};
    diff     = lvl_x - {1'b0, hyst_l};
    sum      = lvl_x + {1'b0, hyst_l};
    lo       = diff[DATA_W] ? '0 : diff;
    hi       = (sum > D_MAX) ? D_MAX : sum;
    set_e    = edge_l ? (d_x > hi) : (d_x < lo);
    fire_c   = arm_e && (edge_l ? (d_x <= lvl_x) : (d_x >= lvl_x));
    tick     = (div_cnt == decim_l);
    acc_arm  = arm && !abort && (state == IDLE || state == DONE);
    wr_en    = tick && (state inside {FILL_PRE, ARMED, POST});
    fire     = tick && state == ARMED && fire_c;
    force_t  = tick && state == ARMED && !fire_c && mode_l == 2'b01 && tmo_l != '0
               && tmo_cnt == tmo_l - T_ONE;
    trig     = fire || force_t;
    post_len = P_DEPTH - {1'b0, pretrig_l};
  end
  // The pretrig port width already bounds the value to DEPTH-1, so no explicit clamp is needed.
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: state_n = arm ? ((pretrig == '0) ? ARMED : FILL_PRE) : state;
      FILL_PRE:   state_n = (tick && pre_cnt + A_ONE == pretrig_l) ? ARMED : state;
      ARMED:      state_n = trig ? ((post_len == P_ONE) ? DONE : POST) : state;
      POST:       state_n = (tick && post_cnt + P_ONE == post_len) ? DONE : state;
      default:    state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data_in;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_l   <= '0;
      hyst_l    <= '0;
      edge_l    <= 1'b0;
      mode_l    <= '0;
      decim_l   <= '0;
      pretrig_l <= '0;
      tmo_l     <= '0;
      div_cnt   <= '0;
      arm_e     <= 1'b0;
      pre_cnt   <= '0;
      tmo_cnt   <= '0;
      post_cnt  <= '0;
      wr_ptr    <= '0;
      start_ptr <= '0;
      forced    <= 1'b0;
      busy      <= 1'b0;
      armed     <= 1'b0;
      done      <= 1'b0;
      rd_data   <= '0;
    end else begin
      div_cnt <= (acc_arm || tick) ? '0 : div_cnt + D_ONE;
      if (acc_arm) begin
        level_l   <= level;
        hyst_l    <= hyst;
        edge_l    <= edge_fall;
        mode_l    <= mode;
        decim_l   <= decim;
        pretrig_l <= pretrig;
        tmo_l     <= auto_tmo;
        arm_e     <= 1'b0;
        pre_cnt   <= '0;
        tmo_cnt   <= '0;
        post_cnt  <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + A_ONE;
        if (tick && (state == FILL_PRE || state == ARMED)) arm_e <= fire ? 1'b0 : (arm_e || set_e);
        if (tick && state == FILL_PRE) pre_cnt <= pre_cnt + A_ONE;
        if (tick && state == ARMED) tmo_cnt <= tmo_cnt + T_ONE;
        if (trig) begin
          start_ptr <= wr_ptr - pretrig_l;
          forced    <= force_t;
          post_cnt  <= P_ONE;
        end else if (tick && state == POST) post_cnt <= post_cnt + P_ONE;
      end
      busy    <= state_n inside {FILL_PRE, ARMED, POST};
      armed   <= state_n == ARMED;
      done    <= state_n == DONE;
      rd_data <= mem[start_ptr + rd_addr];
    end
  end
endmodule

// File: tb/tb_trigger_capture.sv
// tb_trigger_capture: directed scenarios with a readback scoreboard for trigger_capture.
module tb_trigger_capture;
  localparam int DATA_W = 12, DEPTH = 512, ADDR_W = 9, DECIM_W = 16, TMO_W = 24;
  logic clk = 1'b0, rst = 1'b0;
  logic [DATA_W-1:0] data_in = '0, level = '0, hyst = '0;
  logic edge_fall = 1'b0, arm = 1'b0, abort = 1'b0;
  logic [1:0] mode = '0;
  logic [DECIM_W-1:0] decim = '0;
  logic [ADDR_W-1:0] pretrig = '0, rd_addr = '0;
  logic [TMO_W-1:0] auto_tmo = '0;
  logic [DATA_W-1:0] rd_data;
  logic busy, armed, done, forced;
  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  int a_cyc, p_cyc, cnt;

  always #5 clk = ~clk;

  trigger_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DECIM_W(DECIM_W), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .level(level), .hyst(hyst), .edge_fall(edge_fall),
    .mode(mode), .decim(decim), .pretrig(pretrig), .auto_tmo(auto_tmo), .arm(arm), .abort(abort),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .armed(armed), .done(done), .forced(forced)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int lv, input int hy, input int ef, input int md, input int dc, input int pt, input int tm);
    level = DATA_W'(lv);
    hyst = DATA_W'(hy);
    edge_fall = (ef != 0);
    mode = 2'(md);
    decim = DECIM_W'(dc);
    pretrig = ADDR_W'(pt);
    auto_tmo = TMO_W'(tm);
  endtask

  // Arms on the first value, then steps the input by inc per clock until done or budget runs out.
  task automatic run(input int start, input int inc, input int budget, output int armed_cyc, output int post_cyc);
    int v = start;
    bit seen = 0;
    armed_cyc = 0;
    post_cyc = 0;
    data_in = DATA_W'(v);
    arm = 1'b1;
    step();
    arm = 1'b0;
    if (armed) begin armed_cyc++; seen = 1; end
    for (int n = 0; n < budget && !done; n++) begin
      v = v + inc;
      v = (v < 0) ? 0 : ((v > 4095) ? 4095 : v);
      data_in = DATA_W'(v);
      step();
      if (armed) begin armed_cyc++; seen = 1; end
      else if (busy && seen) post_cyc++;
    end
    chk("run_done", 32'(done), 1);
  endtask

  task automatic rd(input string tag, input int idx, input int exp);
    rd_addr = ADDR_W'(idx);
    exp_q.push_back(32'(exp));
    step();
    chk(tag, 32'(rd_data), exp_q.pop_front());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_armed", 32'(armed), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_forced", 32'(forced), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    rst = 1'b1;
    step();

    // Rising edge, no decimation, no pretrigger.
    cfg(2000, 8, 0, 0, 0, 0, 0);
    run(0, 1, 5000, a_cyc, p_cyc);
    chk("rise_post_cycles", 32'(p_cyc), 511);
    chk("rise_forced", 32'(forced), 0);
    for (int i = 0; i < DEPTH; i++) rd("rise_rd", i, 2000 + i);

    // Falling edge with 100 pretrigger samples.
    cfg(1000, 50, 1, 0, 0, 100, 0);
    run(4095, -1, 5000, a_cyc, p_cyc);
    chk("fall_post_cycles", 32'(p_cyc), 411);
    for (int i = 0; i < DEPTH; i++) rd("fall_rd", i, 1100 - i);

    // Hysteresis: oscillation around level must not fire until the input dips below level-hyst.
    cfg(2000, 100, 0, 0, 0, 1, 0);
    data_in = 12'd1950;
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int i = 0; i < 40; i++) begin
      data_in = (i % 2 == 0) ? 12'd2050 : 12'd1950;
      step();
      chk("hyst_no_fire", 32'(armed), 1);
    end
    data_in = 12'd1890;
    step();
    chk("hyst_dip_armed", 32'(armed), 1);
    data_in = 12'd2050;
    step();
    chk("hyst_fired_armed", 32'(armed), 0);
    chk("hyst_fired_busy", 32'(busy), 1);
    for (int n = 0; n < 1000 && !done; n++) step();
    chk("hyst_done", 32'(done), 1);
    rd("hyst_rd0", 0, 1890);
    rd("hyst_rd1", 1, 2050);
    rd("hyst_rd2", 2, 2050);
    rd("hyst_rd511", 511, 2050);

    // Decimation by 48 with auto-mode forced trigger after 10 ticks.
    cfg(3000, 10, 0, 1, 47, 0, 10);
    run(500, 0, 30000, a_cyc, p_cyc);
    chk("auto_armed_cycles", 32'(a_cyc), 480);
    chk("auto_forced", 32'(forced), 1);
    for (int i = 0; i < DEPTH; i++) rd("auto_rd", i, 500);

    // Single mode: arm during POST ignored, DONE holds, arm+abort goes IDLE.
    cfg(2000, 8, 0, 2, 0, 0, 0);
    data_in = '0;
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk("single_armed", 32'(armed), 1);
    for (int i = 0; i < 5; i++) step();
    data_in = 12'd3000;
    step();
    chk("single_fired", 32'(armed), 0);
    chk("single_forced", 32'(forced), 0);
    p_cyc = 1;
    for (int n = 0; n < 2000 && !done; n++) begin
      arm = (n == 100);
      step();
      if (busy) p_cyc++;
    end
    arm = 1'b0;
    chk("single_post_cycles", 32'(p_cyc), 511);
    cnt = 0;
    for (int n = 0; n < 1000; n++) begin
      step();
      if (done) cnt++;
    end
    chk("single_hold", 32'(cnt), 1000);
    rd("single_rd0", 0, 3000);
    rd("single_rd511", 511, 3000);
    arm = 1'b1;
    abort = 1'b1;
    step();
    arm = 1'b0;
    abort = 1'b0;
    chk("armabort_done", 32'(done), 0);
    chk("armabort_busy", 32'(busy), 0);
    chk("armabort_armed", 32'(armed), 0);
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk("rearm_armed", 32'(armed), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_armed", 32'(armed), 0);
    chk("abort_busy", 32'(busy), 0);

    // Asynchronous reset mid-POST, then a clean restart.
    cfg(2000, 8, 0, 0, 0, 0, 0);
    data_in = '0;
    rd_addr = 9'd5;
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int v = 1; v <= 2100; v++) begin
      data_in = DATA_W'(v);
      step();
    end
    chk("pre_rst_armed", 32'(armed), 0);
    chk("pre_rst_busy", 32'(busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_armed", 32'(armed), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_forced", 32'(forced), 0);
    chk("arst_rd_data", 32'(rd_data), 0);
    step();
    rst = 1'b1;
    step();
    run(0, 1, 5000, a_cyc, p_cyc);
    chk("restart_post_cycles", 32'(p_cyc), 511);
    rd("restart_rd0", 0, 2000);
    rd("restart_rd5", 5, 2005);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/trigger_capture.md
Name: trigger_capture

Overview:
- Parametrised level/edge trigger with circular capture buffer, pre-trigger depth, sample decimation and auto/normal/single modes.
- Sits between the ADC sample stream and the display/readout logic.
- Replaces the wide parallel buffer output with an addressed read port: one registered word per request, with the oldest capture sample at logical address 0.

Parameters:
- DATA_W, 12: sample width.
- DEPTH, 512: capture depth in samples; power of two, at least 4.
- ADDR_W, $clog2(DEPTH): buffer address width.
- DECIM_W, 16: width of the decimation divider.
- TMO_W, 24: width of the auto-mode timeout counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- data_in  in  DATA_W  ADC sample, unsigned.
- level  in  DATA_W  trigger level.
- hyst  in  DATA_W  hysteresis band.
- edge_fall  in  1  edge select: 0 = rising, 1 = falling.
- mode  in  2  capture mode: 00 normal, 01 auto, 10 single, 11 treated as normal.
- decim  in  DECIM_W  decimation: sample every decim+1 clocks.
- pretrig  in  ADDR_W  number of pre-trigger samples.
- auto_tmo  in  TMO_W  auto-mode timeout, in sample ticks.
- arm  in  1  pulse: start a capture.
- abort  in  1  pulse: return to IDLE.
- rd_addr  in  ADDR_W  logical read index.
- rd_data  out  DATA_W  buffer word at rd_addr; 1-cycle latency.
- busy  out  1  high in FILL_PRE, ARMED and POST.
- armed  out  1  high in ARMED.
- done  out  1  high in DONE.
- forced  out  1  the last capture was auto-forced.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; rd_data, busy, armed, done, forced = 0; all pointers and counters = 0. Buffer RAM contents are not cleared.
- Config latch: level, hyst, edge_fall, mode, decim, pretrig and auto_tmo are latched on an accepted arm. Later changes have no effect until the next arm.
- pretrig clamp: a pretrig value above DEPTH-1 is clamped to DEPTH-1.
- Sample tick:
  - Divider counts 0..decim_l; tick is asserted when the count equals decim_l, then the divider clears.
  - decim=0 gives a tick every clock.
  - The divider clears on arm.
  - All buffer writes and edge logic advance only on ticks.
- Edge qualifier, rising (edge_fall=0):
  - Flag arm_e is set on a tick with data_in < level-hyst. The subtraction saturates at 0.
  - Fire on a tick with arm_e=1 and data_in >= level; arm_e clears on fire.
- Edge qualifier, falling: mirror of rising.
  - arm_e is set when data_in > level+hyst. The addition saturates at 2^DATA_W-1.
  - Fire when data_in <= level.
- arm_e clears on arm. Comparisons are unsigned, computed at DATA_W+1 bits.
- States:
  - IDLE: arm -> FILL_PRE, or -> ARMED if pretrig_l=0.
  - FILL_PRE: write each tick and count. After pretrig_l writes -> ARMED. arm_e tracking is active; fire is ignored.
  - ARMED: write each tick.
    - fire -> POST; trig_ptr = the write pointer of this sample; forced=0.
    - In mode 01, the timeout counter counts ticks. At auto_tmo ticks without fire, a forced trigger is taken the same way, with forced=1.
    - auto_tmo=0 disables the timeout.
  - POST:
    - The trigger sample counts as the first post sample.
    - After DEPTH-pretrig_l total post samples -> DONE.
    - start_ptr = trig_ptr - pretrig_l, mod DEPTH.
  - DONE:
    - mode single: stay in DONE until arm.
    - mode normal/auto: stay in DONE; arm restarts, going to FILL_PRE or ARMED as from IDLE.
- Priority and overlap:
  - abort in any state -> IDLE, and abort beats a simultaneous arm.
  - arm in FILL_PRE, ARMED or POST is ignored.
- Write pointer: wraps modulo DEPTH. There is no full/overflow condition; the oldest samples are overwritten.
- Read port:
  - Physical address = (start_ptr + rd_addr) mod DEPTH.
  - rd_data is registered: valid on the cycle after rd_addr is presented.
  - Reads are legal in any state, but contents are defined only in DONE.
  - Logical index pretrig_l holds the trigger sample.
- Outputs: busy, armed and done are registered and decode the current state.

Test Plan:
- Reset: assert rst=0 mid-POST -> all outputs 0 in the same cycle, state IDLE; after release, arm restarts cleanly.
- Rising edge, decimation off: DEPTH=512, decim=0, pretrig=0, level=2000, hyst=8, ramp 0..4095 step 1 per clock -> fire on 2000. rd_addr 0..511 returns 2000..2511; forced=0; done asserts after 512 ticks.
- Pretrigger and falling edge: pretrig=100, edge_fall=1, level=1000, hyst=50, ramp 4095 down to 0 -> logical index 100 = 1000, index 0 = 1100, index 511 = 589.
- Hysteresis reject: rising, level=2000, hyst=100, input oscillates 1950 <-> 2050, then dips to 1890 and rises to 2050 -> no fire before the dip; first fire on the 2050 after 1890.
- Decimation plus auto force: decim=47, mode=01, auto_tmo=10, constant input 500 -> forced trigger 480 clocks after entering ARMED; forced=1; all words read 500.
- Single mode and arm/abort priority: after DONE in mode=10 the state holds 1000 clocks. A simultaneous arm+abort -> IDLE. arm pulsed during POST is ignored, with no restart.
